// File: rtl/dot_update_bridge_pkg.sv
// Shared definitions for the dot update bridge.
// Holds the memory map (X/Y blocks, status word, RNG address), the screen limits,
// the status word bit positions, the pairing FSM states and the layout of one FIFO
// entry (id, x, y = 28 bits).
package dot_update_bridge_pkg;

  localparam logic [31:0] RNG_ADDR    = 32'd99;
  localparam logic [31:0] X_BASE      = 32'd100;
  localparam logic [31:0] NUM_DOTS    = 32'd450;
  localparam logic [31:0] Y_BASE      = X_BASE + NUM_DOTS;
  localparam logic [31:0] Y_END       = Y_BASE + NUM_DOTS;
  localparam logic [31:0] STATUS_ADDR = 32'd1000;

  localparam logic [31:0] H_RES = 32'd640;
  localparam logic [31:0] V_RES = 32'd480;

  localparam int FIFO_DEPTH = 8;
  localparam int ENTRY_W    = 28;

  localparam int STAT_OVERFLOW_BIT = 15;
  localparam int STAT_RANGE_BIT    = 14;
  localparam int STAT_ORPHAN_BIT   = 13;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_HAVE_X = 1'b1
  } pair_state_t;

  typedef struct packed {
    logic [8:0] id;
    logic [9:0] x;
    logic [8:0] y;
  } dot_upd_t;

endpackage

// File: rtl/dot_update_bridge_fifo.sv
// Synchronous FIFO with registered storage, used for completed dot updates.
// Ports: clock, reset (sync, active low), push/push_data, pop, head (entry at the
// read pointer), full, empty, count (0..DEPTH).
// A pop is ignored when empty. When full, a push is accepted only if a pop happens
// in the same cycle, so a simultaneous push/pop on a full FIFO keeps count at DEPTH.
module dot_update_bridge_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dot_update_bridge.sv
// Bridge between the processor data-memory write port and the VGA dot renderer.
// Pairs an X write with the matching Y write into one atomic (id, x, y) update,
// queues it, and offers it to the renderer.
// Ports:
//   clock, reset (sync, active low)
//   wren, address_dmem, data : processor write port
//   status_q, status_hit     : status word and its address match (combinational)
//   upd_valid/upd_ready      : renderer handshake; upd_id/upd_x/upd_y head entry
//   pair_state               : pairing FSM state (0 idle, 1 holding an X)
// Handshake: an entry transfers on every clock where upd_valid && upd_ready. While
// upd_valid is high and upd_ready low, upd_id/x/y hold steady. upd_valid does not
// depend on upd_ready.
module dot_update_bridge
  import dot_update_bridge_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] status_q,
  output logic        status_hit,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [8:0]  upd_id,
  output logic [9:0]  upd_x,
  output logic [8:0]  upd_y,
  output logic        pair_state
);

  pair_state_t state;
  logic [8:0]  pend_id;
  logic [9:0]  pend_x;
  logic        overflow;
  logic        range_err;
  logic        orphan_err;

  logic        x_wr, y_wr, x_ok, y_ok, id_match, pair_done;
  logic        set_range, set_orphan, set_overflow, clear_flags;
  logic [8:0]  x_id, y_id;
  logic        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  dot_upd_t    push_entry, head_entry;

  always_comb begin
    x_wr         = wren && (address_dmem >= X_BASE) && (address_dmem < Y_BASE);
    y_wr         = wren && (address_dmem >= Y_BASE) && (address_dmem < Y_END);
    x_id         = 9'(address_dmem - X_BASE);
    y_id         = 9'(address_dmem - Y_BASE);
    x_ok         = (data < H_RES);
    y_ok         = (data < V_RES);
    id_match     = (state == ST_HAVE_X) && (y_id == pend_id);
    pair_done    = y_wr && y_ok && id_match;
    set_range    = (x_wr && !x_ok) || (y_wr && !y_ok);
    set_orphan   = y_wr && y_ok && !id_match;
    // A completed pair is lost only if the FIFO is full and nothing leaves this cycle.
    set_overflow = pair_done && fifo_full && !(upd_valid && upd_ready);
    clear_flags  = wren && (address_dmem == STATUS_ADDR);
    push_entry   = '{id: pend_id, x: pend_x, y: data[8:0]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pend_id    <= '0;
      pend_x     <= '0;
      overflow   <= 1'b0;
      range_err  <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (x_wr && x_ok) begin
            pend_id <= x_id;
            pend_x  <= data[9:0];
            state   <= ST_HAVE_X;
          end
        end
        ST_HAVE_X: begin
          if (x_wr && x_ok) begin
            pend_id <= x_id;
            pend_x  <= data[9:0];
          end else if (pair_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A new error in the same cycle as a clear leaves the flag set.
      overflow   <= set_overflow | (overflow   & ~clear_flags);
      range_err  <= set_range    | (range_err  & ~clear_flags);
      orphan_err <= set_orphan   | (orphan_err & ~clear_flags);
    end
  end

  dot_update_bridge_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pair_done),
    .push_data (push_entry),
    .pop       (upd_ready),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign upd_valid  = !fifo_empty;
  assign upd_id     = head_entry.id;
  assign upd_x      = head_entry.x;
  assign upd_y      = head_entry.y;
  assign pair_state = state;
  assign status_hit = (address_dmem == STATUS_ADDR);

  always_comb begin
    status_q                    = '0;
    status_q[STAT_OVERFLOW_BIT] = overflow;
    status_q[STAT_RANGE_BIT]    = range_err;
    status_q[STAT_ORPHAN_BIT]   = orphan_err;
    status_q[7:0]               = 8'(fifo_count);
  end

endmodule

// File: tb/tb_dot_update_bridge.sv
// Bench for dot_update_bridge: directed write sequences, a queue-based model of
// the pairing/FIFO/flag rules, a per-cycle compare, and literal spot checks.
module tb_dot_update_bridge;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] status_q;
  logic        status_hit;
  logic        upd_valid;
  logic        upd_ready;
  logic [8:0]  upd_id;
  logic [9:0]  upd_x;
  logic [8:0]  upd_y;
  logic        pair_state;

  int checks = 0;
  int errors = 0;

  dot_update_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .status_q     (status_q),
    .status_hit   (status_hit),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_id       (upd_id),
    .upd_x        (upd_x),
    .upd_y        (upd_y),
    .pair_state   (pair_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  logic [27:0] exp_q[$];
  bit          m_pend;
  int          m_pid;
  int          m_px;
  bit          m_ovf, m_rng, m_orph;
  bit          m_pop, m_full, m_push;
  logic [27:0] m_entry;

  always @(posedge clock) begin
    if (!reset) begin
      exp_q.delete();
      m_pend = 0; m_pid = 0; m_px = 0;
      m_ovf = 0; m_rng = 0; m_orph = 0;
    end else begin
      m_pop  = (exp_q.size() != 0) && upd_ready;
      m_full = (exp_q.size() == 8);
      m_push = 0;
      if (wren && address_dmem == 1000) begin
        m_ovf = 0; m_rng = 0; m_orph = 0;
      end
      if (wren && address_dmem >= 100 && address_dmem < 550) begin
        if (data < 640) begin
          m_pend = 1; m_pid = address_dmem - 100; m_px = data;
        end else m_rng = 1;
      end else if (wren && address_dmem >= 550 && address_dmem < 1000) begin
        if (data >= 480) m_rng = 1;
        else if (!m_pend || m_pid != address_dmem - 550) m_orph = 1;
        else begin
          m_pend  = 0;
          m_push  = 1;
          m_entry = {m_pid[8:0], m_px[9:0], data[8:0]};
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) exp_q.push_back(m_entry);
        else m_ovf = 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  logic [31:0] exp_status;
  always @(negedge clock) begin
    if (reset) begin
      exp_status = {16'b0, m_ovf, m_rng, m_orph, 5'b0, 8'(exp_q.size())};
      check("model_status", status_q, exp_status);
      check("model_valid", {31'b0, upd_valid}, {31'b0, exp_q.size() != 0});
      check("model_pair_state", {31'b0, pair_state}, {31'b0, m_pend});
      check("model_status_hit", {31'b0, status_hit}, {31'b0, address_dmem == 1000});
      if (exp_q.size() != 0 && upd_valid)
        check("model_head", {4'b0, upd_id, upd_x, upd_y}, {4'b0, exp_q[0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wr(input int addr, input int val);
    wren = 1'b1; address_dmem = addr; data = val;
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0; data = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; wren = 1'b0; address_dmem = '0; data = '0; upd_ready = 1'b0;
    tick(2);
    check("reset_status", status_q, 32'h0);
    check("reset_valid", {31'b0, upd_valid}, 32'h0);
    check("reset_head", {4'b0, upd_id, upd_x, upd_y}, 32'h0);
    reset = 1'b1;
    tick(1);

    // Basic pair
    upd_ready = 1'b1;
    wr(100, 37);
    wr(550, 200);
    check("basic_valid", {31'b0, upd_valid}, 32'h1);
    check("basic_entry", {22'b0, upd_id, upd_x}, {22'b0, 9'd0, 10'd37});
    check("basic_y", {23'b0, upd_y}, 32'd200);
    tick(1);
    check("basic_popped", {31'b0, upd_valid}, 32'h0);
    check("basic_count", {24'b0, status_q[7:0]}, 32'h0);

    // Last X wins, orphan Y
    upd_ready = 1'b0;
    wr(105, 10);
    wr(107, 20);
    wr(555, 30);
    check("orphan_flag", {31'b0, status_q[13]}, 32'h1);
    check("orphan_no_push", {31'b0, upd_valid}, 32'h0);
    check("orphan_have_x", {31'b0, pair_state}, 32'h1);
    wr(557, 40);
    check("lastx_valid", {31'b0, upd_valid}, 32'h1);
    check("lastx_entry", {4'b0, upd_id, upd_x, upd_y}, {4'b0, 9'd7, 10'd20, 9'd40});
    tick(2);
    check("hold_stable", {4'b0, upd_id, upd_x, upd_y}, {4'b0, 9'd7, 10'd20, 9'd40});
    upd_ready = 1'b1;
    tick(1);
    wr(1000, 32'hFFFF_FFFF);
    check("clear_after_orphan", status_q, 32'h0);

    // Range errors
    wr(103, 640);
    check("range_x_flag", {31'b0, status_q[14]}, 32'h1);
    check("range_x_empty", {31'b0, upd_valid}, 32'h0);
    check("range_x_idle", {31'b0, pair_state}, 32'h0);
    wr(101, 639);
    wr(551, 480);
    check("range_y_have_x", {31'b0, pair_state}, 32'h1);
    wr(551, 479);
    check("range_edge_entry", {4'b0, upd_id, upd_x, upd_y}, {4'b0, 9'd1, 10'd639, 9'd479});
    tick(1);
    wr(1000, 0);
    check("range_cleared", status_q, 32'h0);

    // Overflow: nine pairs into eight slots
    upd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(100 + i, i * 3);
      wr(550 + i, i * 2);
    end
    check("ovf_status", status_q, 32'h0000_8008);
    upd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_id", {23'b0, upd_id}, i);
      tick(1);
    end
    check("ovf_drained", {31'b0, upd_valid}, 32'h0);
    wr(1000, 0);

    // Full FIFO with push and pop on the same edge
    upd_ready = 1'b0;
    for (int i = 10; i < 18; i++) begin
      wr(100 + i, i);
      wr(550 + i, i);
    end
    wr(118, 18);
    wren = 1'b1; address_dmem = 568; data = 18; upd_ready = 1'b1;
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0; data = '0; upd_ready = 1'b0;
    check("simul_status", status_q, 32'h0000_0008);
    check("simul_head", {23'b0, upd_id}, 32'd11);
    upd_ready = 1'b1;
    for (int i = 11; i < 19; i++) begin
      check("simul_drain_id", {23'b0, upd_id}, i);
      tick(1);
    end
    check("simul_drained", {31'b0, upd_valid}, 32'h0);

    // Reset mid-pair
    wr(102, 5);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    wr(552, 6);
    check("rst_pair_orphan", status_q, 32'h0000_2000);
    check("rst_pair_empty", {31'b0, upd_valid}, 32'h0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
